// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned DSIZE_DEF = 32;
  localparam int unsigned ASIZE_DEF = 5;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned PW_DEF    = 2;

  // Saturation value of a pending counter at the default width
  localparam int unsigned PEND_MAX = 2 ** PW_DEF - 1;

  // Pending-count update: add the issue, remove writeback and kill, floor at zero
  function automatic int unsigned cnt_update(input int unsigned cnt, input logic inc,
                                             input logic dec_w, input logic dec_k);
    int sum;
    sum = int'(cnt) + int'(inc) - int'(dec_w) - int'(dec_k);
    if (sum < 0) begin
      return 0;
    end
    return unsigned'(sum);
  endfunction

endpackage

// File: rtl/regfile_sb_counter.sv
// Single pending-write counter for one architectural register.
module sb_counter
  import regfile_sb_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          dec_w_i,
  input  logic          dec_k_i,
  output logic [PW-1:0] cnt_o,
  output logic          sat_o,
  output logic          underflow_o
);

  localparam logic [PW-1:0] PendMax = PW'(2 ** PW - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Next count, clamped at zero
  always_comb begin
    cnt_d = PW'(cnt_update(32'(cnt_q), inc_i, dec_w_i, dec_k_i));
  end

  // Counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Status flags: saturated, and a decrement that would go below zero
  always_comb begin
    sat_o       = (cnt_q == PendMax);
    underflow_o = (32'(cnt_q) + 32'(inc_i)) < (32'(dec_w_i) + 32'(dec_k_i));
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD read ports, write-first bypass and a per-register
// pending-write scoreboard for RAW hazard detection in ID.
// Optional checker: define REGFILE_SB_CHECK_EN to enable the sticky err flag.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned ASIZE = ASIZE_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned PW    = PW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*ASIZE-1:0] raddr,
  output logic [NRD*DSIZE-1:0] rdata,
  output logic [NRD-1:0]       hazard,
  input  logic                 wen,
  input  logic [ASIZE-1:0]     waddr,
  input  logic [DSIZE-1:0]     wdata,
  input  logic                 iss_valid,
  input  logic [ASIZE-1:0]     iss_waddr,
  output logic                 iss_ready,
  input  logic                 kill_valid,
  input  logic [ASIZE-1:0]     kill_waddr,
  output logic                 err
);

  localparam int unsigned NReg = 2 ** ASIZE;

  logic [DSIZE-1:0] regs_q [NReg];
  logic [PW-1:0]    cnt    [NReg];
  logic [NReg-1:0]  inc, dec_w, dec_k, sat, underflow;

  // Register storage; register 0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NReg; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wen && waddr != '0) begin
      regs_q[waddr] <= wdata;
    end
  end

  // One-hot writeback and kill decrements, register 0 excluded
  always_comb begin
    dec_w = '0;
    dec_k = '0;
    if (wen && waddr != '0) begin
      dec_w[waddr] = 1'b1;
    end
    if (kill_valid && kill_waddr != '0) begin
      dec_k[kill_waddr] = 1'b1;
    end
  end

  // Stall issue only on a saturated counter that is not draining this cycle
  always_comb begin
    iss_ready = 1'b1;
    if (iss_waddr != '0 && sat[iss_waddr] && !dec_w[iss_waddr] && !dec_k[iss_waddr]) begin
      iss_ready = 1'b0;
    end
  end

  // One-hot accepted-issue increment
  always_comb begin
    inc = '0;
    if (iss_valid && iss_ready && iss_waddr != '0) begin
      inc[iss_waddr] = 1'b1;
    end
  end

  assign cnt[0]       = '0;
  assign sat[0]       = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < NReg; r++) begin : g_cnt
    sb_counter #(
      .PW (PW)
    ) u_cnt (
      .clk_i       (clk),
      .rst_ni      (rst),
      .inc_i       (inc[r]),
      .dec_w_i     (dec_w[r]),
      .dec_k_i     (dec_k[r]),
      .cnt_o       (cnt[r]),
      .sat_o       (sat[r]),
      .underflow_o (underflow[r])
    );
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ASIZE-1:0] ra;
    logic [DSIZE-1:0] rd;
    logic             hz;

    assign ra = raddr[i*ASIZE +: ASIZE];

    // Read mux with writeback bypass; hazard uses the pre-issue count less
    // any retirement landing this cycle
    always_comb begin
      rd = '0;
      hz = 1'b0;
      if (ra != '0) begin
        rd = (wen && waddr == ra) ? wdata : regs_q[ra];
        hz = 32'(cnt[ra]) > (32'(dec_w[ra]) + 32'(dec_k[ra]));
      end
    end

    assign rdata[i*DSIZE +: DSIZE] = rd;
    assign hazard[i]               = hz;
  end

`ifdef REGFILE_SB_CHECK_EN
  logic err_q;

  // Sticky error on counter underflow or an issue presented while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((|underflow) || (iss_valid && !iss_ready)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

`ifndef SYNTHESIS
  int unsigned sim_cycle;

  // Simulation-only report of the offending register and cycle
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sim_cycle <= 0;
    end else begin
      sim_cycle <= sim_cycle + 1;
      for (int r = 1; r < NReg; r++) begin
        if (underflow[r]) begin
          $display("regfile_sb: pending underflow on r%0d at cycle %0d", r, sim_cycle);
        end
      end
      if (iss_valid && !iss_ready) begin
        $display("regfile_sb: issue to r%0d while stalled at cycle %0d", iss_waddr, sim_cycle);
      end
    end
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;

`ifdef REGFILE_SB_CHECK_EN
  localparam logic CheckEn = 1'b1;
`else
  localparam logic CheckEn = 1'b0;
`endif

  logic        clk, rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  hazard;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        iss_ready;
  logic        kill_valid;
  logic [4:0]  kill_waddr;
  logic        err;

  int total = 0;
  int bad   = 0;

  regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .rdata      (rdata),
    .hazard     (hazard),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .iss_valid  (iss_valid),
    .iss_waddr  (iss_waddr),
    .iss_ready  (iss_ready),
    .kill_valid (kill_valid),
    .kill_waddr (kill_waddr),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_waddr = '0; kill_valid = 1'b0; kill_waddr = '0;
    #3;
    chk("rst_rdata0", rdata[31:0], 32'h0);
    chk("rst_hazard", {30'b0, hazard}, 32'h0);
    chk("rst_ready", {31'b0, iss_ready}, 32'h1);
    chk("rst_err", {31'b0, err}, 32'h0);
    #4 rst = 1'b1;

    // Write r5, read it back; r0 stays zero even when written
    cyc();
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    cyc();
    wen = 1'b0; raddr = {5'd0, 5'd5};
    #1 chk("r5_read", rdata[31:0], 32'hDEADBEEF);
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_waddr = 5'd0;
    #1 chk("r0_bypass", rdata[63:32], 32'h0);
    chk("r0_iss_ready", {31'b0, iss_ready}, 32'h1);
    cyc();
    wen = 1'b0; iss_valid = 1'b0;
    #1 chk("r0_read", rdata[63:32], 32'h0);
    chk("r0_no_hazard", {31'b0, hazard[1]}, 32'h0);

    // Same-cycle bypass
    wen = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr = {5'd0, 5'd7};
    #1 chk("byp_rdata0", rdata[31:0], 32'h12345678);
    chk("byp_hazard0", {31'b0, hazard[0]}, 32'h0);
    cyc();
    wen = 1'b0;
    #1 chk("r7_stored", rdata[31:0], 32'h12345678);

    // RAW hazard on r3
    iss_valid = 1'b1; iss_waddr = 5'd3; raddr = {5'd3, 5'd0};
    #1 chk("raw_self", {31'b0, hazard[1]}, 32'h0);
    cyc();
    iss_valid = 1'b0;
    #1 chk("raw_c1", {31'b0, hazard[1]}, 32'h1);
    cyc();
    #1 chk("raw_c2", {31'b0, hazard[1]}, 32'h1);
    cyc();
    wen = 1'b1; waddr = 5'd3; wdata = 32'hAB;
    #1 chk("raw_wb_clear", {31'b0, hazard[1]}, 32'h0);
    chk("raw_wb_data", rdata[63:32], 32'hAB);
    cyc();
    wen = 1'b0;
    #1 chk("raw_after", {31'b0, hazard[1]}, 32'h0);
    chk("err_clean", {31'b0, err}, 32'h0);

    // Saturation on r4
    iss_valid = 1'b1; iss_waddr = 5'd4; raddr = {5'd0, 5'd4};
    #1 chk("sat_ready0", {31'b0, iss_ready}, 32'h1);
    cyc(); cyc(); cyc();
    iss_valid = 1'b0;
    #1 chk("sat_full", {31'b0, iss_ready}, 32'h0);
    chk("sat_hazard", {31'b0, hazard[0]}, 32'h1);
    wen = 1'b1; waddr = 5'd4; wdata = 32'h44; iss_valid = 1'b1;
    #1 chk("sat_drain_ready", {31'b0, iss_ready}, 32'h1);
    cyc();
    wen = 1'b0; iss_valid = 1'b0;
    #1 chk("sat_stays3", {31'b0, iss_ready}, 32'h0);
    chk("sat_err_pre", {31'b0, err}, 32'h0);
    iss_valid = 1'b1;
    cyc();
    iss_valid = 1'b0;
    #1 chk("sat_err", {31'b0, err}, {31'b0, CheckEn});
    chk("sat_still_full", {31'b0, iss_ready}, 32'h0);

    // Kill plus writeback on r9
    iss_valid = 1'b1; iss_waddr = 5'd9; raddr = {5'd0, 5'd9};
    cyc(); cyc();
    iss_valid = 1'b0;
    #1 chk("k_hazard2", {31'b0, hazard[0]}, 32'h1);
    wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    #1 chk("k_wb_only", {31'b0, hazard[0]}, 32'h1);
    chk("k_bypass", rdata[31:0], 32'h99);
    kill_valid = 1'b1; kill_waddr = 5'd9;
    #1 chk("k_wb_kill", {31'b0, hazard[0]}, 32'h0);
    cyc();
    wen = 1'b0; kill_valid = 1'b0;
    #1 chk("k_cnt0", {31'b0, hazard[0]}, 32'h0);
    kill_valid = 1'b1;
    cyc();
    kill_valid = 1'b0;
    #1 chk("k_clamp", {31'b0, hazard[0]}, 32'h0);
    chk("k_ready", {31'b0, iss_ready}, 32'h1);
    chk("k_err", {31'b0, err}, {31'b0, CheckEn});
    iss_valid = 1'b1;
    cyc();
    iss_valid = 1'b0;
    #1 chk("k_reissue", {31'b0, hazard[0]}, 32'h1);

    // Asynchronous reset between edges
    wen = 1'b1; waddr = 5'd3; wdata = 32'h55;
    cyc();
    wen = 1'b0; iss_valid = 1'b1; iss_waddr = 5'd3;
    cyc(); cyc();
    iss_valid = 1'b0; raddr = {5'd3, 5'd9};
    #1 chk("ar_hazard_pre", {31'b0, hazard[1]}, 32'h1);
    chk("ar_rdata_pre", rdata[63:32], 32'h55);
    #2 rst = 1'b0;
    iss_waddr = 5'd4;
    #1 chk("ar_hazard", {30'b0, hazard}, 32'h0);
    chk("ar_rdata", rdata[63:32], 32'h0);
    chk("ar_err", {31'b0, err}, 32'h0);
    chk("ar_ready", {31'b0, iss_ready}, 32'h1);
    #2 rst = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
